// File: rtl/smart_viol_ctrl_pkg.sv
// Shared definitions for the SMART violation controller: FSM states,
// register word offsets and STATUS bit positions.
package smart_viol_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    GUARD  = 2'd2,
    LOCKED = 2'd3
  } viol_state_e;

  localparam logic [1:0] REG_STATUS    = 2'd0;
  localparam logic [1:0] REG_LAST_ADDR = 2'd1;
  localparam logic [1:0] REG_LAST_PC   = 2'd2;

  localparam int STAT_STICKY  = 8;
  localparam int STAT_LOCKED  = 9;
  localparam int STAT_BUSY    = 10;
  localparam int STAT_CLR_CNT = 15;

endpackage

// File: rtl/smart_viol_regs.sv
// Peripheral-bus front end of the violation controller: address decode,
// combinational read mux and the STATUS clear strobes.
module smart_viol_regs
  import smart_viol_ctrl_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = 15'h0190
) (
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  input  logic [7:0]  viol_cnt,
  input  logic        sticky,
  input  logic        locked,
  input  logic        busy,
  input  logic [15:0] last_addr,
  input  logic [15:0] last_pc,
  output logic [15:0] per_dout,
  output logic        clr_sticky,
  output logic        clr_cnt
);

  localparam logic [13:0] BASE_WORD = BASE_ADDR[14:1];

  logic [13:0] offset;
  logic        hit;
  logic        rd_en;
  logic        wr_status;
  logic [15:0] status;
  logic        unused_din;

  // Addresses below the base wrap to large offsets and fall out of the window
  assign offset    = per_addr - BASE_WORD;
  assign hit       = per_en && (offset < 14'd3);
  assign rd_en     = hit && (per_we == 2'b00);
  assign wr_status = hit && (per_we != 2'b00) && (offset[1:0] == REG_STATUS);

  always_comb begin
    status               = '0;
    status[7:0]          = viol_cnt;
    status[STAT_STICKY]  = sticky;
    status[STAT_LOCKED]  = locked;
    status[STAT_BUSY]    = busy;
  end

  always_comb begin
    per_dout = '0;
    if (rd_en) begin
      case (offset[1:0])
        REG_STATUS:    per_dout = status;
        REG_LAST_ADDR: per_dout = last_addr;
        REG_LAST_PC:   per_dout = last_pc;
        default:       per_dout = '0;
      endcase
    end
  end

  // The count is frozen once the device has locked
  assign clr_sticky = wr_status && per_din[STAT_STICKY];
  assign clr_cnt    = wr_status && per_din[STAT_CLR_CNT] && !locked;

  assign unused_din = ^{per_din[14:9], per_din[7:0]};

endmodule

// File: rtl/smart_viol_ctrl.sv
// Stretches SMART access violations into a system reset request, logs the
// faulting address/PC, counts violations and locks after a threshold.
module smart_viol_ctrl
  import smart_viol_ctrl_pkg::*;
#(
  parameter int          SIZE_MEM_ADDR  = 15,
  parameter int          RST_CYCLES     = 16,
  parameter int          GUARD_CYCLES   = 4,
  parameter int          LOCK_THRESHOLD = 8,
  parameter logic [14:0] BASE_ADDR      = 15'h0190
) (
  input  logic                   mclk,
  input  logic                   reset,
  input  logic                   viol,
  input  logic [SIZE_MEM_ADDR:0] viol_addr,
  input  logic [15:0]            viol_pc,
  input  logic                   disable_debug,
  input  logic [13:0]            per_addr,
  input  logic [15:0]            per_din,
  input  logic                   per_en,
  input  logic [1:0]             per_we,
  output logic [15:0]            per_dout,
  output logic                   sys_rst_req,
  output logic                   locked
);

  viol_state_e state;
  logic [15:0] timer;
  logic [7:0]  viol_cnt;
  logic [7:0]  next_cnt;
  logic        sticky;
  logic [15:0] last_addr;
  logic [15:0] last_pc;
  logic        clr_sticky;
  logic        clr_cnt;
  logic        accept;
  logic        lock_now;

  assign accept   = viol && !disable_debug && (state == IDLE);
  assign next_cnt = (viol_cnt == 8'hFF) ? viol_cnt : viol_cnt + 8'd1;
  assign lock_now = (LOCK_THRESHOLD != 0) && (int'(next_cnt) >= LOCK_THRESHOLD);

  // Capture assignments come after the clear strobes so a same-cycle
  // violation overrides a W1C and counts from the pre-clear value.
  always_ff @(posedge mclk) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      viol_cnt    <= '0;
      sticky      <= 1'b0;
      last_addr   <= '0;
      last_pc     <= '0;
      sys_rst_req <= 1'b0;
      locked      <= 1'b0;
    end else begin
      if (clr_sticky) sticky <= 1'b0;
      if (clr_cnt) viol_cnt <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            last_addr   <= 16'(viol_addr);
            last_pc     <= viol_pc;
            sticky      <= 1'b1;
            viol_cnt    <= next_cnt;
            sys_rst_req <= 1'b1;
            if (lock_now) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end else begin
              state <= HOLD;
              timer <= 16'(RST_CYCLES - 1);
            end
          end
        end
        HOLD: begin
          if (timer == '0) begin
            state       <= GUARD;
            timer       <= 16'(GUARD_CYCLES - 1);
            sys_rst_req <= 1'b0;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        GUARD: begin
          if (timer == '0) state <= IDLE;
          else timer <= timer - 16'd1;
        end
        LOCKED: begin
          sys_rst_req <= 1'b1;
          locked      <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  smart_viol_regs #(
    .BASE_ADDR (BASE_ADDR)
  ) u_regs (
    .per_addr   (per_addr),
    .per_din    (per_din),
    .per_en     (per_en),
    .per_we     (per_we),
    .viol_cnt   (viol_cnt),
    .sticky     (sticky),
    .locked     (locked),
    .busy       (state != IDLE),
    .last_addr  (last_addr),
    .last_pc    (last_pc),
    .per_dout   (per_dout),
    .clr_sticky (clr_sticky),
    .clr_cnt    (clr_cnt)
  );

endmodule

// File: tb/tb_smart_viol_ctrl.sv
// Bench for smart_viol_ctrl: directed scenarios followed by random traffic,
// all compared against a timeline-based model of the controller.
module tb_smart_viol_ctrl;

  localparam int          RST  = 16;
  localparam int          GRD  = 4;
  localparam int          THR  = 8;
  localparam logic [13:0] BASE_W = 14'h00C8;

  logic        mclk = 1'b0;
  logic        reset = 1'b1;
  logic        viol = 1'b0;
  logic [15:0] viol_addr = '0;
  logic [15:0] viol_pc = '0;
  logic        disable_debug = 1'b0;
  logic [13:0] per_addr = '0;
  logic [15:0] per_din = '0;
  logic        per_en = 1'b0;
  logic [1:0]  per_we = '0;
  logic [15:0] per_dout;
  logic        sys_rst_req;
  logic        locked;

  int total = 0;
  int passed = 0;
  int failed = 0;

  // Model: each accepted violation opens a window of edge indices during
  // which the request is high and a longer one during which viol is ignored.
  int          m_j = 0;
  int          m_rst_last = -1;
  int          m_busy_last = -1;
  int          m_cnt = 0;
  bit          m_sticky = 0;
  bit          m_locked = 0;
  logic [15:0] m_addr = '0;
  logic [15:0] m_pc = '0;

  smart_viol_ctrl dut (
    .mclk          (mclk),
    .reset         (reset),
    .viol          (viol),
    .viol_addr     (viol_addr),
    .viol_pc       (viol_pc),
    .disable_debug (disable_debug),
    .per_addr      (per_addr),
    .per_din       (per_din),
    .per_en        (per_en),
    .per_we        (per_we),
    .per_dout      (per_dout),
    .sys_rst_req   (sys_rst_req),
    .locked        (locked)
  );

  always #5 mclk = ~mclk;

  function automatic bit exp_rst();
    return m_locked || (m_j <= m_rst_last);
  endfunction

  function automatic logic [15:0] exp_status();
    int busy;
    busy = (m_locked || (m_j <= m_busy_last)) ? 1 : 0;
    return 16'(m_cnt + 256 * int'(m_sticky) + 512 * int'(m_locked) + 1024 * busy);
  endfunction

  task automatic modelEdge(input bit v, input logic [15:0] a, input logic [15:0] pc,
                           input bit dd, input bit wr, input logic [1:0] woff,
                           input logic [15:0] din, input bit rs);
    bit idle;
    int pre;
    m_j++;
    if (rs) begin
      m_rst_last = -1; m_busy_last = -1; m_cnt = 0;
      m_sticky = 0; m_locked = 0; m_addr = '0; m_pc = '0;
    end else begin
      idle = !m_locked && ((m_j - 1) > m_busy_last);
      pre = m_cnt;
      if (wr && woff == 2'd0 && din[8]) m_sticky = 0;
      if (wr && woff == 2'd0 && din[15] && !m_locked) m_cnt = 0;
      if (v && !dd && idle) begin
        m_addr = a;
        m_pc = pc;
        m_sticky = 1;
        m_cnt = (pre == 255) ? 255 : pre + 1;
        if (THR != 0 && m_cnt >= THR) m_locked = 1;
        else begin
          m_rst_last = m_j + RST - 1;
          m_busy_last = m_j + RST + GRD - 1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [15:0] a, input logic [15:0] pc,
                               input bit dd, input bit wr, input logic [1:0] woff,
                               input logic [15:0] din, input bit rs);
    viol = v; viol_addr = a; viol_pc = pc; disable_debug = dd;
    per_en = wr; per_we = wr ? 2'b11 : 2'b00;
    per_addr = BASE_W + 14'(woff); per_din = din; reset = rs;
    @(posedge mclk);
    modelEdge(v, a, pc, dd, wr, woff, din, rs);
    #1;
    viol = 0; disable_debug = 0; per_en = 0; per_we = 0; per_din = 0; reset = 0;
  endtask

  task automatic idleStep();
    applyStimulus(0, 16'h0, 16'h0, 0, 0, 2'd0, 16'h0, 0);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic readReg(input logic [1:0] off, output logic [15:0] d);
    per_en = 1; per_we = 2'b00; per_addr = BASE_W + 14'(off);
    #1;
    d = per_dout;
    per_en = 0; per_addr = '0;
  endtask

  task automatic checkAll(input string tag);
    logic [15:0] d;
    checkOutput({tag, "/sys_rst_req"}, 16'(sys_rst_req), 16'(exp_rst()));
    checkOutput({tag, "/locked"}, 16'(locked), 16'(m_locked));
    readReg(2'd0, d); checkOutput({tag, "/STATUS"}, d, exp_status());
    readReg(2'd1, d); checkOutput({tag, "/LAST_ADDR"}, d, m_addr);
    readReg(2'd2, d); checkOutput({tag, "/LAST_PC"}, d, m_pc);
  endtask

  initial begin
    logic [15:0] d;
    int          rst_high;
    bit          v, dd, wr, rs;

    $display("[TB] reset");
    applyStimulus(0, 16'h0, 16'h0, 0, 0, 2'd0, 16'h0, 1);
    applyStimulus(0, 16'h0, 16'h0, 0, 0, 2'd0, 16'h0, 1);
    checkAll("reset");
    readReg(2'd0, d); checkOutput("reset_status_zero", d, 16'h0000);
    checkOutput("reset_rst_low", 16'(sys_rst_req), 16'h0000);

    $display("[TB] single violation with re-pulses in HOLD and GUARD");
    idleStep(); checkAll("pre_viol");
    rst_high = 0;
    applyStimulus(1, 16'h0210, 16'hE004, 0, 0, 2'd0, 16'h0, 0);
    checkAll("viol_edge");
    if (sys_rst_req) rst_high++;
    readReg(2'd0, d); checkOutput("hold_status", d, 16'h0501);
    readReg(2'd1, d); checkOutput("hold_last_addr", d, 16'h0210);
    readReg(2'd2, d); checkOutput("hold_last_pc", d, 16'hE004);
    applyStimulus(1, 16'h1234, 16'h5678, 0, 0, 2'd0, 16'h0, 0);
    checkAll("repulse_hold");
    if (sys_rst_req) rst_high++;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(i == 15, 16'h4444, 16'h7777, 0, 0, 2'd0, 16'h0, 0);
      checkAll("hold_guard_seq");
      if (sys_rst_req) rst_high++;
    end
    checkOutput("rst_pulse_len", 16'(rst_high), 16'd16);
    readReg(2'd0, d); checkOutput("after_guard_status", d, 16'h0101);
    readReg(2'd2, d); checkOutput("after_guard_pc", d, 16'hE004);

    $display("[TB] disable_debug");
    applyStimulus(0, 16'h0, 16'h0, 0, 0, 2'd0, 16'h0, 1);
    applyStimulus(1, 16'h0300, 16'hC000, 1, 0, 2'd0, 16'h0, 0);
    checkAll("disable_debug");
    readReg(2'd0, d); checkOutput("dd_status", d, 16'h0000);
    checkOutput("dd_rst", 16'(sys_rst_req), 16'h0000);

    $display("[TB] W1C racing a violation");
    applyStimulus(1, 16'h0400, 16'hC010, 0, 1, 2'd0, 16'h0100, 0);
    checkAll("w1c_race");
    readReg(2'd0, d); checkOutput("w1c_race_status", d, 16'h0501);
    for (int i = 0; i < 20; i++) begin idleStep(); checkAll("w1c_wait"); end
    applyStimulus(0, 16'h0, 16'h0, 0, 1, 2'd0, 16'h0100, 0);
    readReg(2'd0, d); checkOutput("w1c_clear", d, 16'h0001);
    applyStimulus(0, 16'h0, 16'h0, 0, 1, 2'd1, 16'hFFFF, 0);
    checkAll("ro_write");
    applyStimulus(0, 16'h0, 16'h0, 0, 1, 2'd0, 16'h8000, 0);
    readReg(2'd0, d); checkOutput("cnt_clear", d, 16'h0000);

    $display("[TB] lock after threshold");
    for (int n = 0; n < THR; n++) begin
      applyStimulus(1, 16'(16'h0500 + n), 16'(16'hD000 + n), 0, 0, 2'd0, 16'h0, 0);
      checkAll("lock_viol");
      if (n < THR - 1)
        for (int i = 0; i < 20; i++) begin idleStep(); checkAll("lock_gap"); end
    end
    checkOutput("locked_flag", 16'(locked), 16'h0001);
    readReg(2'd0, d); checkOutput("locked_status", d, 16'h0708);
    applyStimulus(0, 16'h0, 16'h0, 0, 1, 2'd0, 16'h8000, 0);
    readReg(2'd0, d); checkOutput("locked_cnt_hold", d, 16'h0708);
    for (int i = 0; i < 25; i++) begin
      applyStimulus(i == 3, 16'h9999, 16'h9999, 0, 0, 2'd0, 16'h0, 0);
      checkAll("locked_stay");
    end
    checkOutput("locked_rst_high", 16'(sys_rst_req), 16'h0001);
    per_en = 0; per_addr = BASE_W; #1;
    checkOutput("dout_no_en", per_dout, 16'h0000);
    per_en = 1; per_we = 2'b01; #1;
    checkOutput("dout_on_write", per_dout, 16'h0000);
    per_we = 2'b00; per_addr = BASE_W + 14'd3; #1;
    checkOutput("dout_out_of_range", per_dout, 16'h0000);
    per_addr = BASE_W - 14'd1; #1;
    checkOutput("dout_below_base", per_dout, 16'h0000);
    per_en = 0; per_addr = '0;
    applyStimulus(0, 16'h0, 16'h0, 0, 0, 2'd0, 16'h0, 1);
    checkAll("unlock_reset");
    readReg(2'd0, d); checkOutput("unlock_status", d, 16'h0000);

    $display("[TB] reset mid-HOLD");
    applyStimulus(1, 16'h0600, 16'hBEEF, 0, 0, 2'd0, 16'h0, 0);
    for (int i = 0; i < 4; i++) begin idleStep(); checkAll("mid_hold"); end
    applyStimulus(0, 16'h0, 16'h0, 0, 0, 2'd0, 16'h0, 1);
    checkOutput("midhold_rst", 16'(sys_rst_req), 16'h0000);
    readReg(2'd0, d); checkOutput("midhold_status", d, 16'h0000);
    readReg(2'd2, d); checkOutput("midhold_pc", d, 16'h0000);
    applyStimulus(1, 16'h0700, 16'hA5A5, 0, 0, 2'd0, 16'h0, 0);
    checkAll("post_reset_viol");
    readReg(2'd0, d); checkOutput("post_reset_status", d, 16'h0501);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 99) < 30);
      dd = ($urandom_range(0, 7) == 0);
      wr = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 59) == 0);
      applyStimulus(v, 16'($urandom), 16'($urandom), dd, wr,
                    2'($urandom_range(0, 2)), 16'($urandom), rs);
      checkAll("random");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/smart_viol_ctrl.md
Name: smart_viol_ctrl

Overview:
- Downstream consumer of the SMART memory-access controller's violation output (its `reset` pulse, qualified by `mem_addr` and `ins_addr`).
- Turns each single-cycle violation into a clean, stretched system reset request.
- Records the faulting data address and PC, and counts violations.
- Locks the device permanently after a configurable number of violations. Status is exposed on the openMSP430 peripheral bus.

Parameters:
- SIZE_MEM_ADDR, 15, MSB index of the violation address (address width = SIZE_MEM_ADDR+1).
- RST_CYCLES, 16, cycles sys_rst_req is held high per violation (must be >=1).
- GUARD_CYCLES, 4, cycles after release during which new violations are ignored (must be >=1).
- LOCK_THRESHOLD, 8, violation count that forces LOCKED; 0 disables locking.
- BASE_ADDR, 15'h0190, byte base address of the register block (word aligned).

Ports:
- mclk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- viol  in  1  violation pulse from the memory-access controller
- viol_addr  in  SIZE_MEM_ADDR+1  memory address at violation
- viol_pc  in  16  instruction address at violation
- disable_debug  in  1  high: ignore viol entirely
- per_addr  in  14  peripheral word address
- per_din  in  16  peripheral write data
- per_en  in  1  peripheral access enable
- per_we  in  2  byte write enables (any nonzero = write)
- per_dout  out  16  peripheral read data (0 when not selected)
- sys_rst_req  out  1  stretched reset request to the reset generator
- locked  out  1  permanent lock indicator

Behaviour:
- Reset: state=IDLE; counters, viol_cnt, sticky, last_addr, last_pc all 0; sys_rst_req=0; locked=0.
- Accepted violation: viol=1 & ~disable_debug & state==IDLE.
- State machine (state register drives sys_rst_req and locked; no combinational path from viol):
  - IDLE: on an accepted violation in cycle T, at T+1:
    - last_addr<=viol_addr, last_pc<=viol_pc (zero-extend addr to 16 bits), sticky<=1.
    - viol_cnt<=viol_cnt+1, saturating at 255.
    - If LOCK_THRESHOLD!=0 and the new count >= LOCK_THRESHOLD, go to LOCKED; else go to HOLD with hold counter = RST_CYCLES-1.
  - HOLD: sys_rst_req=1. It is high for exactly RST_CYCLES cycles (T+1..T+RST_CYCLES), then state moves to GUARD with guard counter = GUARD_CYCLES-1.
  - GUARD: sys_rst_req=0. viol is ignored (no capture, no count). After exactly GUARD_CYCLES cycles, state moves to IDLE.
  - LOCKED: sys_rst_req=1, locked=1. Left only by reset. viol is ignored.
- viol during HOLD/GUARD/LOCKED is dropped silently. A viol that is high for several cycles counts once per IDLE visit.
- Register map (word offsets from BASE_ADDR>>1):
  - +0 STATUS: [7:0] viol_cnt, [8] sticky, [9] locked, [10] busy (state!=IDLE), others 0.
  - +1 LAST_ADDR.
  - +2 LAST_PC.
- Reads are combinational: per_dout = selected register when per_en & per_we==0 & address hit, else 0.
- Writes:
  - STATUS bit8=1 clears sticky (W1C).
  - STATUS bit15=1 clears viol_cnt, but only when not LOCKED.
  - All other bits and registers are read-only; writes to them are ignored.
- Simultaneous accepted violation and W1C in the same cycle: the violation wins (sticky=1, count increments from the pre-clear value).
- reset asserted in any state, mid-HOLD included: returns to the reset values in the next cycle; sys_rst_req drops.

Decomposition:
- Shared package (smart_defines include):
  - state encoding: IDLE=2'd0, HOLD=2'd1, GUARD=2'd2, LOCKED=2'd3
  - register offsets STATUS/LAST_ADDR/LAST_PC
  - STATUS bit positions
- One natural sub-module: smart_viol_regs, holding the peripheral decode, read mux and W1C logic. The FSM and counters remain in the top.

Test Plan:
- 1-cycle viol at T with viol_addr=16'h0210, viol_pc=16'hE004 -> sys_rst_req high T+1..T+16; STATUS=16'h0501 during HOLD; LAST_ADDR=0210, LAST_PC=E004; STATUS=16'h0101 after GUARD.
- viol re-pulsed at T+2 (HOLD) and T+18 (GUARD) -> ignored; viol_cnt stays 1; sys_rst_req pulse still 16 cycles.
- disable_debug=1 with viol pulse -> no change; STATUS=0, sys_rst_req=0.
- 8 separated violations with LOCK_THRESHOLD=8 -> after the 8th: locked=1, sys_rst_req stays 1, STATUS=16'h0708; write 16'h8000 -> count unchanged; reset -> all 0.
- Write STATUS=16'h0100 in the same cycle as an accepted viol -> sticky=1, viol_cnt+1; a later write of 16'h0100 alone clears sticky.
- reset at HOLD cycle 5 -> next cycle sys_rst_req=0, STATUS=0, LAST_PC=0; a fresh viol is accepted immediately afterward.
